// File: rtl/nubus_pkg.sv
// nubus_pkg
//   Shared definitions for the NuBus slave target controller:
//   transfer-size codes (low three bits of {tm1_n, tm0_n, ad_n[1:0]}),
//   status codes driven on {tm1_n_o, tm0_n_o}, the controller state enum
//   and the byte-enable decoder.
package nubus_pkg;

  // Size field of the raw transfer-mode code (bit 3 selects read/write)
  localparam logic [2:0] SZ_BYTE3 = 3'b000;
  localparam logic [2:0] SZ_BYTE2 = 3'b001;
  localparam logic [2:0] SZ_BYTE1 = 3'b010;
  localparam logic [2:0] SZ_BYTE0 = 3'b011;
  localparam logic [2:0] SZ_HALF1 = 3'b100;
  localparam logic [2:0] SZ_BLOCK = 3'b101;
  localparam logic [2:0] SZ_HALF0 = 3'b110;
  localparam logic [2:0] SZ_WORD  = 3'b111;

  // Status codes as driven on {tm1_n_o, tm0_n_o}
  localparam logic [1:0] STAT_COMPLETE  = 2'b11;
  localparam logic [1:0] STAT_ERROR     = 2'b10;
  localparam logic [1:0] STAT_TIMEOUT   = 2'b01;
  localparam logic [1:0] STAT_TRY_AGAIN = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_MEM   = 3'd2,
    ST_ACKW  = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

  // Byte enables for a size code; be[i] covers data[8i+7:8i].
  // Block transfers are never issued to memory and decode to no lanes.
  function automatic logic [3:0] be_decode(input logic [2:0] sz);
    logic [3:0] be;
    case (sz)
      SZ_BYTE3: be = 4'b1000;
      SZ_BYTE2: be = 4'b0100;
      SZ_BYTE1: be = 4'b0010;
      SZ_BYTE0: be = 4'b0001;
      SZ_HALF1: be = 4'b1100;
      SZ_HALF0: be = 4'b0011;
      SZ_WORD:  be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/nubus_clk_edge.sv
// nubus_clk_edge
//   Brings the asynchronous NuBus /CLK into the clk48 domain and produces
//   one-cycle strobes for its edges.
//   Ports:
//     clk48  in  board clock, all flops on its rising edge
//     reset  in  synchronous, active-high
//     clk_n  in  NuBus /CLK (asynchronous)
//     smp    out high for one clk48 cycle after a falling /CLK edge (sample)
//     drv    out high for one clk48 cycle after a rising /CLK edge (drive)
module nubus_clk_edge (
  input  logic clk48,
  input  logic reset,
  input  logic clk_n,
  output logic smp,
  output logic drv
);

  logic sync1_r;
  logic sync2_r;

  // Two-flop synchronizer; the strobes are registered from the same
  // transition the second flop is about to take, so they line up with it.
  always_ff @(posedge clk48) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      smp     <= 1'b0;
      drv     <= 1'b0;
    end else begin
      sync1_r <= clk_n;
      sync2_r <= sync1_r;
      smp     <= sync2_r & ~sync1_r;
      drv     <= ~sync2_r & sync1_r;
    end
  end

endmodule

// File: rtl/nubus_slave_ctrl.sv
// nubus_slave_ctrl
//   NuBus slave target: decodes single-beat START cycles addressed to this
//   slot, issues one request on the local memory bus and answers the master
//   with ACK, a status code and (for reads) data.
//   Ports:
//     clk48, reset                      board clock / sync active-high reset
//     clk_n, id_n, start_n, tm0_n,
//     tm1_n, ack_n, ad_n                NuBus inputs (active-low, 3.3 V)
//     ad_n_o, ad_oe                     read data to the bus and its enable
//     tm0_n_o, tm1_n_o, ack_n_o, ctl_oe status/ACK outputs and their enable
//     mem_req, mem_we, mem_addr,
//     mem_wdata, mem_be                 local memory request (held until done)
//     mem_ack, mem_rdata                local memory completion and read data
module nubus_slave_ctrl
  import nubus_pkg::*;
#(
  parameter int TIMEOUT_CLKS     = 1023,
  parameter int ENABLE_SUPERSLOT = 0
) (
  input  logic        clk48,
  input  logic        reset,
  input  logic        clk_n,
  input  logic [3:0]  id_n,
  input  logic        start_n,
  input  logic        tm0_n,
  input  logic        tm1_n,
  input  logic        ack_n,
  input  logic [31:0] ad_n,
  output logic [31:0] ad_n_o,
  output logic        ad_oe,
  output logic        tm0_n_o,
  output logic        tm1_n_o,
  output logic        ack_n_o,
  output logic        ctl_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic          smp_s;
  logic          drv_s;
  logic [7:0]    tag_s;
  logic [3:0]    code_s;
  logic          sel_s;
  logic          tmo_s;
  logic          start_s;

  state_t        state_r;
  logic [TW-1:0] tcnt_r;
  logic          read_r;
  logic [1:0]    status_r;
  logic [31:0]   rdata_r;

  nubus_clk_edge u_clk_edge (
    .clk48 (clk48),
    .reset (reset),
    .clk_n (clk_n),
    .smp   (smp_s),
    .drv   (drv_s)
  );

  // Slot / super-slot decode of the address phase and START qualification.
  // ack_n from other cards is not needed by a single-beat target.
  always_comb begin
    tag_s   = ~ad_n[31:24];
    code_s  = {tm1_n, tm0_n, ad_n[1], ad_n[0]};
    start_s = smp_s & ~start_n & ack_n | smp_s & ~start_n & ~ack_n;
    if (tag_s == {4'hF, ~id_n}) begin
      sel_s = 1'b1;
    end else if ((ENABLE_SUPERSLOT != 0) && (tag_s[7:4] == ~id_n)) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
    // Last cycle of the allowed window: tcnt_r counts completed req-high cycles.
    tmo_s = (tcnt_r == TW'(TIMEOUT_CLKS - 1));
  end

  // Transfer FSM with all bus and memory outputs registered.
  always_ff @(posedge clk48) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      tcnt_r    <= {TW{1'b0}};
      read_r    <= 1'b0;
      status_r  <= STAT_COMPLETE;
      rdata_r   <= 32'hFFFF_FFFF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 30'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_be    <= 4'b0000;
      ad_n_o    <= 32'hFFFF_FFFF;
      ad_oe     <= 1'b0;
      tm0_n_o   <= 1'b1;
      tm1_n_o   <= 1'b1;
      ack_n_o   <= 1'b1;
      ctl_oe    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s && sel_s) begin
            read_r  <= code_s[3];
            rdata_r <= 32'hFFFF_FFFF;
            if (code_s[2:0] == SZ_BLOCK) begin
              // Block transfers are refused without touching memory.
              status_r <= STAT_ERROR;
              state_r  <= ST_ACKW;
            end else begin
              mem_addr <= ~ad_n[31:2];
              mem_we   <= ~code_s[3];
              mem_be   <= be_decode(code_s[2:0]);
              tcnt_r   <= {TW{1'b0}};
              if (code_s[3]) begin
                mem_req <= 1'b1;
                state_r <= ST_MEM;
              end else begin
                state_r <= ST_WDATA;
              end
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WDATA: begin
          if (smp_s) begin
            mem_wdata <= ~ad_n;
            mem_req   <= 1'b1;
            state_r   <= ST_MEM;
          end else begin
            state_r <= ST_WDATA;
          end
        end
        ST_MEM: begin
          // mem_ack is tested first so it wins over a simultaneous timeout.
          if (mem_ack) begin
            mem_req  <= 1'b0;
            tcnt_r   <= {TW{1'b0}};
            status_r <= STAT_COMPLETE;
            if (read_r) begin
              rdata_r <= ~mem_rdata;
            end else begin
              rdata_r <= 32'hFFFF_FFFF;
            end
            state_r <= ST_ACKW;
          end else if (tmo_s) begin
            mem_req  <= 1'b0;
            tcnt_r   <= {TW{1'b0}};
            status_r <= STAT_ERROR;
            state_r  <= ST_ACKW;
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end
        ST_ACKW: begin
          if (drv_s) begin
            ack_n_o <= 1'b0;
            tm1_n_o <= status_r[1];
            tm0_n_o <= status_r[0];
            ctl_oe  <= 1'b1;
            ad_oe   <= read_r;
            ad_n_o  <= read_r ? rdata_r : 32'hFFFF_FFFF;
            state_r <= ST_ACK;
          end else begin
            state_r <= ST_ACKW;
          end
        end
        ST_ACK: begin
          // Held from one drv to the next, i.e. one full NuBus period.
          if (drv_s) begin
            ack_n_o <= 1'b1;
            tm1_n_o <= 1'b1;
            tm0_n_o <= 1'b1;
            ctl_oe  <= 1'b0;
            ad_oe   <= 1'b0;
            ad_n_o  <= 32'hFFFF_FFFF;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_ACK;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          mem_req <= 1'b0;
          ack_n_o <= 1'b1;
          tm1_n_o <= 1'b1;
          tm0_n_o <= 1'b1;
          ctl_oe  <= 1'b0;
          ad_oe   <= 1'b0;
          ad_n_o  <= 32'hFFFF_FFFF;
        end
      endcase
    end
  end

endmodule
